// File: rtl/sched_commit_tracker_pkg.sv
// Shared scheduler types: warp lifecycle state, counter default width and slot-match helper.
package sched_commit_tracker_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      DRAINING = 2'd2
   } warp_state_e;

   localparam int PENDING_W_DEF = 4;

   // Upper bounds for the slot-match helper; callers zero-fill unused slots.
   localparam int MAX_SLOTS = 16;
   localparam int MAX_WID_W = 8;

   function automatic int log2up(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Number of slots whose valid bit is set and whose warp id equals wid.
   function automatic int unsigned slot_match_cnt(
      input logic [MAX_SLOTS-1:0]                vld,
      input logic [MAX_SLOTS-1:0][MAX_WID_W-1:0] wids,
      input logic [MAX_WID_W-1:0]                wid
   );
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_SLOTS; i++)
         if (vld[i] && (wids[i] == wid)) n++;
      return n;
   endfunction

endpackage

// File: rtl/sched_pending_counter.sv
// Per-warp in-flight counter: +inc -dec each cycle, clamped at zero with an underflow pulse.
module sched_pending_counter
   import sched_commit_tracker_pkg::*;
#(
   parameter int PENDING_W = PENDING_W_DEF,
   parameter int DEC_W     = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic [DEC_W-1:0]     dec,
   output logic [PENDING_W-1:0] count,
   output logic [PENDING_W-1:0] count_nxt,
   output logic                 underflow
);

   localparam int SW = PENDING_W + 2;

   logic [SW-1:0] sum;

   // Two guard bits: one for inc at max (never taken, issue is gated), one for sign.
   assign sum       = SW'(count) + SW'(inc) - SW'(dec);
   assign underflow = sum[SW-1];
   assign count_nxt = underflow ? '0 : sum[PENDING_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) count <= '0;
      else       count <= count_nxt;
   end

endmodule

// File: rtl/sched_commit_tracker.sv
// Warp in-flight tracker and IDLE/ACTIVE/DRAINING sequencer fed by commit slots.
// Optional perf counters under SCHED_COMMIT_TRACKER_PERF_EN (ports tied to 0 otherwise).
module sched_commit_tracker
   import sched_commit_tracker_pkg::*;
#(
   parameter int WARP_CNT       = 4,
   parameter int ISSUE_CNT      = 4,
   parameter int WARP_CNT_WIDTH = log2up(WARP_CNT),
   parameter int PENDING_W      = PENDING_W_DEF,
   parameter int PERF_CTR_BITS  = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                issue_valid,
   input  logic [WARP_CNT_WIDTH-1:0]           issue_wid,
   output logic                                issue_ready,
   input  logic [ISSUE_CNT-1:0]                committed,
   input  logic [ISSUE_CNT*WARP_CNT_WIDTH-1:0] committed_wid,
   input  logic [ISSUE_CNT-1:0]                halt,
   input  logic                                spawn_valid,
   input  logic [WARP_CNT-1:0]                 spawn_mask,
   output logic [WARP_CNT-1:0]                 active_warps,
   output logic [WARP_CNT-1:0]                 pending_zero,
   output logic                                busy,
   output logic                                underflow_err,
   output logic [PERF_CTR_BITS-1:0]            perf_issue_stalls,
   output logic [PERF_CTR_BITS-1:0]            perf_drain_cycles
);

   localparam int                   DEC_W   = log2up(ISSUE_CNT + 1);
   localparam logic [PENDING_W-1:0] CNT_MAX = '1;

   logic [MAX_SLOTS-1:0]                slot_vld, slot_halt;
   logic [MAX_SLOTS-1:0][MAX_WID_W-1:0] slot_wid;

   warp_state_e                         state_q [WARP_CNT];
   logic [WARP_CNT-1:0][PENDING_W-1:0]  count, count_nxt;
   logic [WARP_CNT-1:0][DEC_W-1:0]      dec;
   logic [WARP_CNT-1:0]                 inc, uf, halt_hit, draining;

   // Spread the flat commit bus into fixed-size slot lanes for the match helper.
   always_comb begin
      slot_vld  = '0;
      slot_halt = '0;
      slot_wid  = '0;
      for (int i = 0; i < ISSUE_CNT; i++) begin
         slot_vld[i]  = committed[i];
         slot_halt[i] = committed[i] & halt[i];
         slot_wid[i]  = MAX_WID_W'(committed_wid[i*WARP_CNT_WIDTH +: WARP_CNT_WIDTH]);
      end
   end

   always_comb begin
      issue_ready = 1'b0;
      for (int w = 0; w < WARP_CNT; w++)
         if (issue_wid == WARP_CNT_WIDTH'(w))
            issue_ready = active_warps[w] && (count[w] != CNT_MAX);
   end

   always_comb begin
      inc = '0;
      for (int w = 0; w < WARP_CNT; w++)
         inc[w] = issue_valid && issue_ready && (issue_wid == WARP_CNT_WIDTH'(w));
   end

   for (genvar w = 0; w < WARP_CNT; w++) begin : g_warp
      assign dec[w]      = DEC_W'(slot_match_cnt(slot_vld, slot_wid, MAX_WID_W'(w)));
      assign halt_hit[w] = slot_match_cnt(slot_halt, slot_wid, MAX_WID_W'(w)) != 0;

      sched_pending_counter #(
         .PENDING_W (PENDING_W),
         .DEC_W     (DEC_W)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .inc       (inc[w]),
         .dec       (dec[w]),
         .count     (count[w]),
         .count_nxt (count_nxt[w]),
         .underflow (uf[w])
      );
   end

   // Spawn is only honoured from IDLE, so a warp finishing its drain this cycle stays IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < WARP_CNT; w++)
            state_q[w] <= (w == 0) ? ACTIVE : IDLE;
      end else begin
         for (int w = 0; w < WARP_CNT; w++) begin
            case (state_q[w])
               IDLE:
                  if (spawn_valid && spawn_mask[w]) state_q[w] <= ACTIVE;
               ACTIVE:
                  if (halt_hit[w]) state_q[w] <= (count_nxt[w] == '0) ? IDLE : DRAINING;
               DRAINING:
                  if (count_nxt[w] == '0) state_q[w] <= IDLE;
               default:
                  state_q[w] <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      active_warps = '0;
      pending_zero = '0;
      draining     = '0;
      busy         = 1'b0;
      for (int w = 0; w < WARP_CNT; w++) begin
         active_warps[w] = (state_q[w] == ACTIVE);
         draining[w]     = (state_q[w] == DRAINING);
         pending_zero[w] = (count[w] == '0);
         busy            = busy | (state_q[w] != IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)    underflow_err <= 1'b0;
      else if (|uf) underflow_err <= 1'b1;
   end

`ifdef SCHED_COMMIT_TRACKER_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issue_stalls <= '0;
         perf_drain_cycles <= '0;
      end else begin
         if (issue_valid && !issue_ready) perf_issue_stalls <= perf_issue_stalls + 1'b1;
         if (|draining)                   perf_drain_cycles <= perf_drain_cycles + 1'b1;
      end
   end
`else
   assign perf_issue_stalls = '0;
   assign perf_drain_cycles = '0;
`endif

endmodule

// File: tb/tb_sched_commit_tracker.sv
// Directed bench for sched_commit_tracker: issue/commit netting, halt/drain, spawn, saturation, underflow.
module tb_sched_commit_tracker;
   import sched_commit_tracker_pkg::*;

   localparam int WARP_CNT  = 4;
   localparam int ISSUE_CNT = 4;
   localparam int WW        = 2;
   localparam int PCB       = 16;

   logic                    clk;
   logic                    reset;
   logic                    issue_valid;
   logic [WW-1:0]           issue_wid;
   logic                    issue_ready;
   logic [ISSUE_CNT-1:0]    committed;
   logic [ISSUE_CNT*WW-1:0] committed_wid;
   logic [ISSUE_CNT-1:0]    halt;
   logic                    spawn_valid;
   logic [WARP_CNT-1:0]     spawn_mask;
   logic [WARP_CNT-1:0]     active_warps;
   logic [WARP_CNT-1:0]     pending_zero;
   logic                    busy;
   logic                    underflow_err;
   logic [PCB-1:0]          perf_issue_stalls;
   logic [PCB-1:0]          perf_drain_cycles;

   int n_chk  = 0;
   int n_fail = 0;

   sched_commit_tracker #(
      .WARP_CNT      (WARP_CNT),
      .ISSUE_CNT     (ISSUE_CNT),
      .PERF_CTR_BITS (PCB)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .issue_valid       (issue_valid),
      .issue_wid         (issue_wid),
      .issue_ready       (issue_ready),
      .committed         (committed),
      .committed_wid     (committed_wid),
      .halt              (halt),
      .spawn_valid       (spawn_valid),
      .spawn_mask        (spawn_mask),
      .active_warps      (active_warps),
      .pending_zero      (pending_zero),
      .busy              (busy),
      .underflow_err     (underflow_err),
      .perf_issue_stalls (perf_issue_stalls),
      .perf_drain_cycles (perf_drain_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      issue_valid   = 1'b0;
      issue_wid     = '0;
      committed     = '0;
      committed_wid = '0;
      halt          = '0;
      spawn_valid   = 1'b0;
      spawn_mask    = '0;
   endtask

   initial begin
      clr_in();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_active",  32'(active_warps),  32'h1);
      chk("rst_pz",      32'(pending_zero),  32'hF);
      chk("rst_busy",    32'(busy),          32'h1);
      chk("rst_uf",      32'(underflow_err), 32'h0);
      chk("rst_ready",   32'(issue_ready),   32'h1);
      chk("rst_perf_st", 32'(perf_issue_stalls), 32'h0);

      // 1: three issues then three single-slot commits
      issue_valid = 1'b1; issue_wid = 2'd0;
      repeat (3) tick();
      issue_valid = 1'b0;
      chk("t1_pz_issued", 32'(pending_zero[0]), 32'h0);
      committed = 4'b0001; committed_wid = '0;
      tick();
      tick();
      chk("t1_pz_cnt1", 32'(pending_zero[0]), 32'h0);
      tick();
      clr_in();
      chk("t1_pz_drained", 32'(pending_zero[0]), 32'h1);
      chk("t1_uf",         32'(underflow_err),   32'h0);

      // 2: count 2, two commits + one issue same cycle -> 1
      issue_valid = 1'b1; issue_wid = 2'd0;
      repeat (2) tick();
      committed = 4'b0011; committed_wid = '0;
      tick();
      clr_in();
      chk("t2_pz_net1", 32'(pending_zero[0]), 32'h0);
      committed = 4'b0001;
      tick();
      clr_in();
      chk("t2_pz_zero", 32'(pending_zero[0]), 32'h1);
      chk("t2_uf",      32'(underflow_err),   32'h0);

      // 3: count 3, halt -> DRAINING, two commits -> IDLE
      issue_valid = 1'b1; issue_wid = 2'd0;
      repeat (3) tick();
      issue_valid = 1'b0;
      committed = 4'b0001; halt = 4'b0001;
      tick();
      clr_in();
      chk("t3_active_drain", 32'(active_warps), 32'h0);
      chk("t3_ready_drain",  32'(issue_ready),  32'h0);
      chk("t3_busy_drain",   32'(busy),         32'h1);
      chk("t3_pz_drain",     32'(pending_zero), 32'hE);
      committed = 4'b0001;
      tick();
      chk("t3_busy_cnt1", 32'(busy), 32'h1);
      tick();
      clr_in();
      chk("t3_busy_idle", 32'(busy),          32'h0);
      chk("t3_pz_idle",   32'(pending_zero),  32'hF);
      chk("t3_uf",        32'(underflow_err), 32'h0);

      // 4: respawn warp 0, count 1, halt -> IDLE in one cycle, then spawn 1011
      spawn_valid = 1'b1; spawn_mask = 4'b0001;
      tick();
      clr_in();
      chk("t4_respawn", 32'(active_warps), 32'h1);
      issue_valid = 1'b1;
      tick();
      clr_in();
      committed = 4'b0001; halt = 4'b0001;
      tick();
      clr_in();
      chk("t4_active_idle", 32'(active_warps), 32'h0);
      chk("t4_busy_idle",   32'(busy),         32'h0);
      spawn_valid = 1'b1; spawn_mask = 4'b1011;
      tick();
      clr_in();
      chk("t4_spawn", 32'(active_warps), 32'hB);
      chk("t4_busy",  32'(busy),         32'h1);

      // 5: saturate warp 1 at 15
      issue_valid = 1'b1; issue_wid = 2'd1;
      repeat (14) tick();
      chk("t5_ready_14", 32'(issue_ready), 32'h1);
      tick();
      chk("t5_ready_15", 32'(issue_ready), 32'h0);
      tick();
      chk("t5_ready_hold", 32'(issue_ready), 32'h0);
      issue_valid = 1'b0;
      committed = 4'b0100; committed_wid = 8'b00_01_00_00;
      tick();
      committed = '0; committed_wid = '0;
      chk("t5_ready_after", 32'(issue_ready),     32'h1);
      chk("t5_pz",          32'(pending_zero),    32'hD);

      // 6: underflow on idle warp 2, sticky; reset mid-operation clears everything
      committed = 4'b0001; committed_wid = 8'b00_00_00_10;
      tick();
      clr_in();
      chk("t6_uf_set",  32'(underflow_err), 32'h1);
      chk("t6_pz",      32'(pending_zero),  32'hD);
      tick();
      chk("t6_uf_held", 32'(underflow_err), 32'h1);
      reset = 1'b1;
      committed = 4'b0001; committed_wid = 8'b00_00_00_01;
      tick();
      reset = 1'b0;
      clr_in();
      chk("t6_uf_rst",     32'(underflow_err), 32'h0);
      chk("t6_pz_rst",     32'(pending_zero),  32'hF);
      chk("t6_active_rst", 32'(active_warps),  32'h1);

      // stall on idle warp 2 for five cycles
      issue_valid = 1'b1; issue_wid = 2'd2;
      repeat (5) tick();
      clr_in();
`ifdef SCHED_COMMIT_TRACKER_PERF_EN
      chk("t6_perf_stalls", 32'(perf_issue_stalls), 32'h5);
`else
      chk("t6_perf_stalls", 32'(perf_issue_stalls), 32'h0);
`endif
      chk("t6_perf_drain", 32'(perf_drain_cycles), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
